// File: rtl/credit_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | credit_pkg: shared types and helpers for the credit-based stream link.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package credit_pkg;

  typedef enum logic {RUN, FLUSH} credit_state_t;

  localparam int STAT_W = 32;

  function automatic int credit_cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/credit_tx_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | credit_counter: saturating up/down counter with load-to-max and overflow.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module credit_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_max_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel, so the count holds even at 0 or MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (load_max_i) begin
      cnt_d = MAX_V;
    end else if (inc_i && !dec_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= MAX_V;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = inc_i && !dec_i && !load_max_i && (cnt_q == MAX_V);

endmodule
`default_nettype wire

// File: rtl/credit_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | credit_tx: transmit end of the credit-based stream link.                   |
// | Optional beat/stall statistics enabled by defining CREDIT_TX_STATS_EN.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module credit_tx
  import credit_pkg::*;
#(
  parameter int  DATA_W   = 32,
  parameter int  CREDITS  = 4,
  parameter int  LINK_LAT = 2,
  localparam int CNT_W    = credit_cnt_w(CREDITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] link_data_o,
  output logic              link_valid_o,
  input  logic              credit_return_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  credits_avail_o,
  output logic              idle_o,
  output logic              credit_err_o
`ifdef CREDIT_TX_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_beats_o,
  output logic [STAT_W-1:0] stat_stalls_o
`endif
);

  localparam logic [0:0]        ST_RUN    = 1'(RUN);
  localparam logic [0:0]        ST_FLUSH  = 1'(FLUSH);
  localparam int                WAIT_W    = (LINK_LAT > 0) ? $clog2(LINK_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LINK_LAT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CREDITS);

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              link_valid_q;
  logic [DATA_W-1:0] link_data_q;
  logic              err_q;
  logic              restore;
  logic              run;
  logic              accept;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;

  assign run        = (state_q == ST_RUN);
  assign in_ready_o = run && (cnt != '0) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  // Returns are only counted in RUN; anything arriving during FLUSH is a
  // stale credit for a slot the remote flush already freed.
  credit_counter #(
    .MAX (CREDITS),
    .W   (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (run && credit_return_i),
    .dec_i      (accept),
    .load_max_i (restore),
    .cnt_o      (cnt),
    .ovf_o      (ovf)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    restore = 1'b0;
    if (state_q == ST_RUN) begin
      if (flush_i) begin
        state_d = ST_FLUSH;
        wait_d  = WAIT_INIT;
      end
    end else begin
      if (flush_i) begin
        wait_d = WAIT_INIT;
      end else if (wait_q == '0) begin
        state_d = ST_RUN;
        restore = 1'b1;
      end else begin
        wait_d = wait_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      wait_q       <= '0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      link_valid_q <= accept;
      if (accept) begin
        link_data_q <= in_data_i;
      end
      if (ovf) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef CREDIT_TX_STATS_EN
  logic [STAT_W-1:0] beats_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (accept) begin
        beats_q <= beats_q + 1'b1;
      end
      if (in_valid_i && !in_ready_o && run) begin
        stalls_q <= stalls_q + 1'b1;
      end
    end
  end

  assign stat_beats_o  = beats_q;
  assign stat_stalls_o = stalls_q;
`endif

  assign link_valid_o    = link_valid_q;
  assign link_data_o     = link_data_q;
  assign credits_avail_o = cnt;
  assign idle_o          = run && (cnt == CNT_MAX);
  assign credit_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_credit_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_credit_tx: self-checking bench for credit_tx (vectors + random model).  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_credit_tx;

  localparam int DATA_W   = 32;
  localparam int CREDITS  = 4;
  localparam int LINK_LAT = 2;
  localparam int CNT_W    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] link_data_o;
  logic              link_valid_o;
  logic              credit_return_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [CNT_W-1:0]  credits_avail_o;
  logic              idle_o;
  logic              credit_err_o;
`ifdef CREDIT_TX_STATS_EN
  logic [31:0]       stat_beats_o;
  logic [31:0]       stat_stalls_o;
`endif

  credit_tx #(
    .DATA_W   (DATA_W),
    .CREDITS  (CREDITS),
    .LINK_LAT (LINK_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data_i       (in_data_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .link_data_o     (link_data_o),
    .link_valid_o    (link_valid_o),
    .credit_return_i (credit_return_i),
    .flush_i         (flush_i),
    .credits_avail_o (credits_avail_o),
    .idle_o          (idle_o),
    .credit_err_o    (credit_err_o)
`ifdef CREDIT_TX_STATS_EN
    ,
    .stat_beats_o    (stat_beats_o),
    .stat_stalls_o   (stat_stalls_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: credits as a plain integer, flush as a countdown.
  int          m_cnt;
  bit          m_in_flush;
  int          m_wait;
  bit          m_err;
  bit          m_lv;
  logic [31:0] m_ld;
  logic [31:0] m_beats;
  logic [31:0] m_stalls;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = CREDITS; m_in_flush = 0; m_wait = 0; m_err = 0;
    m_lv = 0; m_ld = '0; m_beats = '0; m_stalls = '0;
  endtask

  task automatic check_outputs();
    chk("link_valid", 64'(link_valid_o), 64'(m_lv));
    chk("link_data", 64'(link_data_o), 64'(m_ld));
    chk("credits_avail", 64'(credits_avail_o), 64'(m_cnt));
    chk("idle", 64'(idle_o), 64'(!m_in_flush && m_cnt == CREDITS));
    chk("credit_err", 64'(credit_err_o), 64'(m_err));
`ifdef CREDIT_TX_STATS_EN
    chk("stat_beats", 64'(stat_beats_o), 64'(m_beats));
    chk("stat_stalls", 64'(stat_stalls_o), 64'(m_stalls));
`endif
  endtask

  // One clock: drive inputs, check in_ready, advance the model, check outputs.
  task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit f);
    bit rdy, acc;
    in_valid_i = v; in_data_i = d; credit_return_i = r; flush_i = f;
    #1;
    rdy = !m_in_flush && (m_cnt > 0) && !f;
    acc = v && rdy;
    chk("in_ready", 64'(in_ready_o), 64'(rdy));
    m_lv = acc;
    if (acc) begin
      m_ld = d;
      m_beats = m_beats + 1;
    end
    if (v && !rdy && !m_in_flush) m_stalls = m_stalls + 1;
    if (!m_in_flush) begin
      if (r && !acc && m_cnt == CREDITS) m_err = 1;
      m_cnt = m_cnt + int'(r) - int'(acc);
      if (m_cnt > CREDITS) m_cnt = CREDITS;
      if (f) begin
        m_in_flush = 1;
        m_wait = LINK_LAT;
      end
    end else begin
      if (f) m_wait = LINK_LAT;
      else if (m_wait == 0) begin
        m_in_flush = 0;
        m_cnt = CREDITS;
      end else m_wait--;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1; in_valid_i = 0; in_data_i = '0; credit_return_i = 0; flush_i = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    chk("rst_credits", 64'(credits_avail_o), 64'(CREDITS));
    chk("rst_link_valid", 64'(link_valid_o), 64'd0);
    chk("rst_link_data", 64'(link_data_o), 64'd0);
    chk("rst_err", 64'(credit_err_o), 64'd0);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
`ifdef CREDIT_TX_STATS_EN
    chk("rst_stat_beats", 64'(stat_beats_o), 64'd0);
    chk("rst_stat_stalls", 64'(stat_stalls_o), 64'd0);
`endif
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          r;
    bit          f;
    bit          e_rdy;
    bit          e_lv;
    logic [31:0] e_ld;
    int          e_cnt;
    bit          e_idle;
    bit          e_err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  initial begin
    //          v  data   r  f  rdy lv  ld     cnt idle err
    tbl[0]  = '{1, 32'h10, 0, 0, 1, 1, 32'h10, 3, 0, 0};
    tbl[1]  = '{1, 32'h11, 0, 0, 1, 1, 32'h11, 2, 0, 0};
    tbl[2]  = '{1, 32'h12, 0, 0, 1, 1, 32'h12, 1, 0, 0};
    tbl[3]  = '{1, 32'h13, 0, 0, 1, 1, 32'h13, 0, 0, 0};
    tbl[4]  = '{1, 32'h14, 0, 0, 0, 0, 32'h13, 0, 0, 0};
    tbl[5]  = '{1, 32'h15, 0, 0, 0, 0, 32'h13, 0, 0, 0};
    tbl[6]  = '{0, 32'h00, 1, 0, 0, 0, 32'h13, 1, 0, 0};
    tbl[7]  = '{1, 32'h16, 0, 0, 1, 1, 32'h16, 0, 0, 0};
    tbl[8]  = '{0, 32'h00, 1, 0, 0, 0, 32'h16, 1, 0, 0};
    tbl[9]  = '{0, 32'h00, 1, 0, 1, 0, 32'h16, 2, 0, 0};
    tbl[10] = '{1, 32'h17, 1, 0, 1, 1, 32'h17, 2, 0, 0};
    tbl[11] = '{0, 32'h00, 1, 0, 1, 0, 32'h17, 3, 0, 0};
    tbl[12] = '{0, 32'h00, 1, 0, 1, 0, 32'h17, 4, 1, 0};
    tbl[13] = '{0, 32'h00, 1, 0, 1, 0, 32'h17, 4, 1, 1};
    tbl[14] = '{1, 32'h18, 0, 1, 0, 0, 32'h17, 4, 0, 1};
    tbl[15] = '{0, 32'h00, 0, 0, 0, 0, 32'h17, 4, 0, 1};
    tbl[16] = '{0, 32'h00, 0, 0, 0, 0, 32'h17, 4, 0, 1};
    tbl[17] = '{0, 32'h00, 0, 0, 0, 0, 32'h17, 4, 1, 1};
    tbl[18] = '{0, 32'h00, 0, 0, 1, 0, 32'h17, 4, 1, 1};

    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      chk($sformatf("vec%0d_rdy", i), 64'(in_ready_o !== 1'bx ? tbl[i].e_rdy : 1'bx), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_lv", i), 64'(link_valid_o), 64'(tbl[i].e_lv));
      chk($sformatf("vec%0d_ld", i), 64'(link_data_o), 64'(tbl[i].e_ld));
      chk($sformatf("vec%0d_cnt", i), 64'(credits_avail_o), 64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_idle", i), 64'(idle_o), 64'(tbl[i].e_idle));
      chk($sformatf("vec%0d_err", i), 64'(credit_err_o), 64'(tbl[i].e_err));
    end

    // Flush with stale returns in flight: returns ignored, count restored.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'hA0 + 32'(i), 0, 0);
    chk("pre_flush_cnt", 64'(credits_avail_o), 64'd1);
    cycle(1, 32'hAF, 0, 1);
    chk("flush_no_beat", 64'(link_valid_o), 64'd0);
    cycle(0, 0, 1, 0);
    chk("flush_ret_ignored", 64'(credits_avail_o), 64'd1);
    cycle(0, 0, 1, 0);
    chk("flush_still_busy", 64'(idle_o), 64'd0);
    cycle(0, 0, 0, 0);
    chk("flush_done_cnt", 64'(credits_avail_o), 64'd4);
    chk("flush_done_idle", 64'(idle_o), 64'd1);
    chk("flush_done_err", 64'(credit_err_o), 64'd0);
    chk("flush_done_lv", 64'(link_valid_o), 64'd0);

    // Reset in the middle of FLUSH with one credit left.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'hB0 + 32'(i), 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    chk("midflush_cnt", 64'(credits_avail_o), 64'd1);
    rst = 1; flush_i = 1; credit_return_i = 1;
    @(posedge clk);
    #1;
    rst = 0; flush_i = 0; credit_return_i = 0;
    #1;
    chk("rst_mid_cnt", 64'(credits_avail_o), 64'd4);
    chk("rst_mid_lv", 64'(link_valid_o), 64'd0);
    chk("rst_mid_idle", 64'(idle_o), 64'd1);
    chk("rst_mid_ready", 64'(in_ready_o), 64'd1);
`ifdef CREDIT_TX_STATS_EN
    chk("rst_mid_beats", 64'(stat_beats_o), 64'd0);
`endif
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit v, r, f;
      v = ($urandom_range(99, 0) < 70);
      r = ($urandom_range(99, 0) < 35);
      f = ($urandom_range(99, 0) < 4);
      cycle(v, $urandom, r, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
